// File: rtl/main_memory_arbiter_if.sv
// -----------------------------------------------------------------------------
// main_memory_arbiter_if
//   Bundles the instruction port (I), the load/store port (D) and the
//   MainMemory side of the arbiter into one interface.
//   slave  : the arbiter's view (takes requests and mem_rdata, drives ready,
//            read data and the memory controls)
//   master : the surrounding system's view (CPU front end plus MainMemory)
// Signals
//   i_req/i_addr/i_ready/i_rdata                  instruction fetch port
//   d_req/d_write/d_addr/d_wdata/d_ready/d_rdata  load/store port
//   mem_addr/mem_write/mem_wdata/mem_rdata        MainMemory port
//   mem_busy                                      high while an access is in flight
// -----------------------------------------------------------------------------
interface main_memory_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              i_req;
   logic [ADDR_W-1:0] i_addr;
   logic              i_ready;
   logic [DATA_W-1:0] i_rdata;

   logic              d_req;
   logic              d_write;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic              d_ready;
   logic [DATA_W-1:0] d_rdata;

   logic [ADDR_W-1:0] mem_addr;
   logic              mem_write;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_busy;

   modport slave (
      input  i_req, i_addr, d_req, d_write, d_addr, d_wdata, mem_rdata,
      output i_ready, i_rdata, d_ready, d_rdata,
             mem_addr, mem_write, mem_wdata, mem_busy
   );

   modport master (
      output i_req, i_addr, d_req, d_write, d_addr, d_wdata, mem_rdata,
      input  i_ready, i_rdata, d_ready, d_rdata,
             mem_addr, mem_write, mem_wdata, mem_busy
   );
endinterface

// File: rtl/main_memory_arbiter.sv
// -----------------------------------------------------------------------------
// main_memory_arbiter
//   Shares the single-port MainMemory between the instruction fetch port (I)
//   and the load/store port (D). One request is latched at a time, the memory
//   is held for LATENCY cycles, then the owner gets a one-cycle ready pulse.
//   D wins ties unless I has waited MAX_WAIT or more cycles.
// Ports
//   clock  system clock, all state changes on posedge
//   reset  synchronous, active-high
//   bus    main_memory_arbiter_if.slave (I port, D port, MainMemory port)
// -----------------------------------------------------------------------------
module main_memory_arbiter #(
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32,
   parameter int LATENCY  = 2,
   parameter int MAX_WAIT = 8
) (
   input  logic                 clock,
   input  logic                 reset,
   main_memory_arbiter_if.slave bus
);
   localparam int CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam int WAIT_W = $clog2(MAX_WAIT + 1);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   state_t            state, state_nxt;
   logic              owner_d;       // 1: D owns the current access, 0: I
   logic [CNT_W-1:0]  cnt;
   logic [WAIT_W-1:0] i_wait;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [DATA_W-1:0] mem_wdata_q;
   logic              mem_write_q;
   logic [DATA_W-1:0] i_rdata_q;
   logic [DATA_W-1:0] d_rdata_q;

   logic any_req, i_starved, grant_d, grant_i, last_beat;

   assign any_req   = bus.i_req | bus.d_req;
   assign i_starved = (i_wait >= WAIT_W'(MAX_WAIT));
   // Only meaningful in IDLE: D wins unless a starved I is also asking.
   assign grant_d   = bus.d_req & ~(bus.i_req & i_starved);
   assign grant_i   = (state == IDLE) & bus.i_req & ~grant_d;
   assign last_beat = (state == ACCESS) && (cnt == CNT_W'(LATENCY - 1));

   // State register.
   // NOTE: sequential state is assigned with <= so every flop samples the
   // pre-edge values, independent of statement or process order.
   always_ff @(posedge clock) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Next-state logic.
   // NOTE: state_nxt gets a default before the case so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (any_req)   state_nxt = ACCESS;
         ACCESS:  if (last_beat) state_nxt = RESP;
         RESP:                   state_nxt = IDLE;
         default:                state_nxt = IDLE;
      endcase
   end

   // Request latch, access counter and read-data capture.
   always_ff @(posedge clock) begin
      if (reset) begin
         owner_d     <= 1'b0;
         cnt         <= '0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_write_q <= 1'b0;
         i_rdata_q   <= '0;
         d_rdata_q   <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (any_req) begin
                  owner_d     <= grant_d;
                  mem_addr_q  <= grant_d ? bus.d_addr : bus.i_addr;
                  mem_write_q <= grant_d & bus.d_write;
                  // I has no write data; mem_wdata keeps its last value.
                  if (grant_d) mem_wdata_q <= bus.d_wdata;
                  cnt <= '0;
               end
            end
            ACCESS: begin
               cnt <= cnt + CNT_W'(1);
               if (last_beat) begin
                  mem_write_q <= 1'b0;
                  // mem_write_q still holds the latched direction here.
                  if (!mem_write_q) begin
                     if (owner_d) d_rdata_q <= bus.mem_rdata;
                     else         i_rdata_q <= bus.mem_rdata;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // I starvation counter: counts while I asks but is not being served,
   // saturates at MAX_WAIT, clears on the edge that grants I.
   always_ff @(posedge clock) begin
      if (reset)
         i_wait <= '0;
      else if (grant_i)
         i_wait <= '0;
      else if (bus.i_req && !((state != IDLE) && !owner_d) && !i_starved)
         i_wait <= i_wait + WAIT_W'(1);
   end

   // Outputs decoded from state; ready goes to the owner only.
   always_comb begin
      bus.i_ready  = 1'b0;
      bus.d_ready  = 1'b0;
      if (state == RESP) begin
         if (owner_d) bus.d_ready = 1'b1;
         else         bus.i_ready = 1'b1;
      end
      bus.mem_busy = (state == ACCESS);
   end

   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign bus.mem_write = mem_write_q;
   assign bus.i_rdata   = i_rdata_q;
   assign bus.d_rdata   = d_rdata_q;
endmodule
